// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for N writers into one FIFO
//
// Purpose: grants one requester at a time the FIFO write port for up to
//   G_BURST beats, with one idle cycle between grants. The next owner is the
//   first requester found cyclically after the previous owner.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (release synchronised to i_clk)
//   i_req        per-requester write-valid
//   i_data       per-requester data, requester k at [k*G_WIDTH +: G_WIDTH]
//   o_ack        one-hot, beat accepted this cycle
//   i_full       FIFO full flag
//   o_wr         FIFO write enable
//   o_data       FIFO write data
//   o_grant_id   current owner index
//   o_busy       high while a grant is held
//   o_grant_cnt  per-requester saturating grant counts (FIFO_ARB_STATS_EN only)
//
// Build option: define FIFO_ARB_STATS_EN to add o_grant_cnt and its counters.

module fifo_wr_arbiter #(
  parameter int G_WIDTH = 8,
  parameter int G_NREQ  = 4,
  parameter int G_BURST = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [G_NREQ-1:0]           i_req,
  input  logic [G_NREQ*G_WIDTH-1:0]   i_data,
  output logic [G_NREQ-1:0]           o_ack,
  input  logic                        i_full,
  output logic                        o_wr,
  output logic [G_WIDTH-1:0]          o_data,
  output logic [$clog2(G_NREQ)-1:0]   o_grant_id,
  output logic                        o_busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [G_NREQ*16-1:0]        o_grant_cnt
`endif
);

  localparam int IDW = $clog2(G_NREQ);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_last;
  logic [7:0]       r_beats;
  logic             r_busy;
  logic [1:0]       r_rst_sync;

  logic             w_rst_n;
  logic [IDW-1:0]   w_next;
  logic [IDW-1:0]   w_idx;
  logic             w_own_req;
  logic             w_wr;
  logic             w_exit;
  logic [G_WIDTH-1:0] w_din [G_NREQ];

  // Assert passes straight through; release takes two clock edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  for (genvar g = 0; g < G_NREQ; g++) begin : g_din
    assign w_din[g] = i_data[g*G_WIDTH +: G_WIDTH];
  end

  // Scan from the farthest offset down so the nearest requester after
  // r_last is the one left in w_next.
  always_comb begin
    w_next = '0;
    w_idx  = '0;
    for (int i = G_NREQ; i >= 1; i--) begin
      w_idx = IDW'((int'(r_last) + i) % G_NREQ);
      if (i_req[w_idx]) w_next = w_idx;
    end
  end

  assign w_own_req = i_req[r_owner];
  assign w_wr      = (r_state == S_GRANT) && w_own_req && !i_full;
  assign w_exit    = (r_state == S_GRANT) &&
                     (!w_own_req || (w_wr && r_beats == 8'(G_BURST - 1)));

  always_comb begin
    o_ack = '0;
    if (w_wr) o_ack[r_owner] = 1'b1;
  end

  assign o_wr       = w_wr;
  assign o_data     = (r_state == S_GRANT) ? w_din[r_owner] : '0;
  assign o_grant_id = r_owner;
  assign o_busy     = r_busy;

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= IDW'(G_NREQ - 1);
      r_beats <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_owner <= w_next;
            r_beats <= '0;
            r_state <= S_GRANT;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_wr) r_beats <= r_beats + 8'd1;
          if (w_exit) begin
            r_last  <= r_owner;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_cnt [G_NREQ];

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int k = 0; k < G_NREQ; k++) r_cnt[k] <= '0;
    end else if (w_exit && r_cnt[r_owner] != 16'hFFFF) begin
      r_cnt[r_owner] <= r_cnt[r_owner] + 16'd1;
    end
  end

  for (genvar g = 0; g < G_NREQ; g++) begin : g_cnt
    assign o_grant_cnt[g*16 +: 16] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic        i_full;
  logic        o_wr;
  logic [7:0]  o_data;
  logic [1:0]  o_grant_id;
  logic        o_busy;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] o_grant_cnt;
`endif

  fifo_wr_arbiter #(.G_WIDTH(8), .G_NREQ(4), .G_BURST(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .i_full     (i_full),
    .o_wr       (o_wr),
    .o_data     (o_data),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .o_grant_cnt(o_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int id;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Data carries the requester in the top bits and the cycle in the low bits,
  // so a write from the wrong source or the wrong cycle both show up.
  function automatic int dval(input int k, input int c);
    return ((k << 6) | (c & 63)) & 255;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int c, input int id);
    exp_t e;
    e.c  = c;
    e.id = id;
    q.push_back(e);
  endtask

  task automatic tick(input logic [3:0] req, input logic full);
    @(posedge clk);
    #1;
    i_req  = req;
    i_full = full;
    for (int k = 0; k < 4; k++) i_data[k*8 +: 8] = 8'(dval(k, cyc));
  endtask

  task automatic run(input logic [3:0] req, input logic full, input int n);
    for (int i = 0; i < n; i++) tick(req, full);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr"},   int'(o_wr), 0);
    chk({tag, "_ack"},  int'(o_ack), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_gid"},  int'(o_grant_id), 0);
    chk({tag, "_data"}, int'(o_data), 0);
  endtask

  // Monitor: every write pops the scoreboard; an expected write that does
  // not appear on its cycle is also reported.
  always @(negedge clk) begin
    exp_t e;
    if (o_wr) begin
      if (i_full) chk("wr_while_full", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_wr_cycle", cyc, -1);
      end else begin
        e = q.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_id",    int'(o_grant_id), e.id);
        chk("wr_data",  int'(o_data), dval(e.id, e.c));
        chk("wr_ack",   int'(o_ack), 1 << e.id);
      end
    end else begin
      if (o_ack != 4'b0) chk("ack_without_wr", int'(o_ack), 0);
      if (q.size() > 0 && q[0].c == cyc) chk("missed_wr", 0, 1);
    end
  end

  int b;

  initial begin
    rst_n  = 1'b0;
    i_req  = 4'b0;
    i_full = 1'b0;
    i_data = '0;

    run(4'b0000, 1'b0, 2);
    #3 chk_reset_outputs("por");
    tick(4'b0000, 1'b0);
    rst_n = 1'b1;
    run(4'b0000, 1'b0, 4);

    // Single requester: 4 beats, one gap, regrant, then drop after 2 beats.
    tick(4'b0001, 1'b0);
    b = cyc;
    for (int i = 1; i <= 4; i++) push(b + i, 0);
    push(b + 6, 0);
    push(b + 7, 0);
    run(4'b0001, 1'b0, 4);
    tick(4'b0001, 1'b0);
    #3 chk("a_gap_busy", int'(o_busy), 0);
    run(4'b0001, 1'b0, 2);
    tick(4'b0000, 1'b0);
    #3 chk("a_drop_busy", int'(o_busy), 1);
    run(4'b0000, 1'b0, 2);

    // Reset mid-burst: owner 2 (after r_last=0) aborted after 2 beats.
    tick(4'b0100, 1'b0);
    b = cyc;
    push(b + 1, 2);
    push(b + 2, 2);
    run(4'b0100, 1'b0, 2);
    tick(4'b0100, 1'b0);
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("mid");
    run(4'b0000, 1'b0, 2);
    rst_n = 1'b1;
    run(4'b0000, 1'b0, 4);

    // All requesting: 0,1,2,3,0 with 4 beats each, gap between grants.
    tick(4'b1111, 1'b0);
    b = cyc;
    for (int g = 0; g < 5; g++)
      for (int i = 1; i <= 4; i++) push(b + g*5 + i, g % 4);
    run(4'b1111, 1'b0, 24);
    run(4'b0000, 1'b0, 2);

    // Owner 2 stalled by full for 3 cycles after 2 beats, then 2 more.
    tick(4'b0100, 1'b0);
    b = cyc;
    push(b + 1, 2);
    push(b + 2, 2);
    push(b + 6, 2);
    push(b + 7, 2);
    run(4'b0100, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0100, 1'b1);
      #3;
      chk("c_stall_busy", int'(o_busy), 1);
      chk("c_stall_gid",  int'(o_grant_id), 2);
    end
    run(4'b0100, 1'b0, 2);
    tick(4'b0000, 1'b0);
    #3 chk("c_done_busy", int'(o_busy), 0);
    run(4'b0000, 1'b0, 1);

    // Owner 1 drops after 1 beat; with 1010 the next owner must be 3.
    tick(4'b0010, 1'b0);
    b = cyc;
    push(b + 1, 1);
    for (int i = 4; i <= 7; i++) push(b + i, 3);
    tick(4'b0010, 1'b0);
    tick(4'b1000, 1'b0);
    tick(4'b1010, 1'b0);
    #3 chk("d_exit_busy", int'(o_busy), 0);
    run(4'b1010, 1'b0, 4);
    tick(4'b0000, 1'b0);
    #3 chk("d_end_busy", int'(o_busy), 0);
    run(4'b0000, 1'b0, 3);

`ifdef FIFO_ARB_STATS_EN
    for (int k = 0; k < 4; k++) chk("grant_cnt", int'(o_grant_cnt[k*16 +: 16]), 2);
`endif

    chk("scoreboard_left", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter G_WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter G_NREQ, default 4, meaning the number of requesters (2..8).
REQ-003 The block SHALL have parameter G_BURST, default 4, meaning the maximum number of beats per grant (1..255).
REQ-004 The block SHALL have port i_clk, input, 1, the single clock.
REQ-005 The block SHALL have port i_rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port i_req, input, G_NREQ, the per-requester write-valid.
REQ-007 The block SHALL have port i_data, input, G_NREQ*G_WIDTH, the per-requester data, with requester k at bits [k*G_WIDTH +: G_WIDTH].
REQ-008 The block SHALL have port o_ack, output, G_NREQ, a one-hot flag meaning the beat is accepted this cycle.
REQ-009 The block SHALL have port i_full, input, 1, the FIFO full flag.
REQ-010 The block SHALL have port o_wr, output, 1, the FIFO write enable.
REQ-011 The block SHALL have port o_data, output, G_WIDTH, the FIFO write data.
REQ-012 The block SHALL have port o_grant_id, output, $clog2(G_NREQ), the current owner index.
REQ-013 The block SHALL have port o_busy, output, 1, which is high while in GRANT.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and GRANT, with state, owner, last-owner and a beat counter held in registers.
REQ-015 In IDLE with any i_req bit set, the block SHALL latch as owner the first requesting index cyclically after r_last, clear the beat counter, and enter GRANT on the next edge; with no request it SHALL stay in IDLE.
REQ-016 In GRANT, o_wr SHALL be combinational and equal i_req[owner] & ~i_full; o_data SHALL be i_data[owner]; o_ack SHALL be o_wr one-hot at the owner.
REQ-017 In IDLE, o_wr and o_ack SHALL be 0 and o_data SHALL be 0.
REQ-018 Each cycle with o_wr=1 SHALL increment the beat counter by 1, and cycles with i_full=1 SHALL NOT count.
REQ-019 GRANT SHALL exit to IDLE, setting r_last=owner, on the edge where the counted beat equals G_BURST or where i_req[owner]=0.
REQ-020 The minimum latency from a request in IDLE to the first o_wr SHALL be 1 cycle.
REQ-021 Arbitration SHALL include one idle gap cycle between grants.
REQ-022 i_full=1 during GRANT SHALL stall without releasing the grant; no write SHALL ever be issued while i_full=1.
REQ-023 Requests from non-owners SHALL be ignored and SHALL receive o_ack=0.
REQ-024 With a single active requester, that requester SHALL be regranted after each gap.
REQ-025 Index wrap-around SHALL use the cyclic order G_NREQ-1 followed by 0.

Reset
REQ-026 Asserting i_rst_n low SHALL immediately force state=IDLE, owner=0, r_last=G_NREQ-1 (so requester 0 has first priority), beat counter=0, o_busy=0, o_grant_id=0, o_wr=0, and o_ack=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no further write, and deassertion SHALL be synchronised to i_clk.

Configuration
REQ-028 When FIFO_ARB_STATS_EN is defined, the block SHALL add output o_grant_cnt, G_NREQ*16 bits, holding per-requester saturating counts of completed grants (increment on GRANT exit, hold at 16'hFFFF, reset to 0).
REQ-029 When FIFO_ARB_STATS_EN is undefined, the block SHALL have neither the port nor the counters, and its behaviour SHALL otherwise be identical.

Verification
REQ-030 Reset then i_req=4'b0001 held for 6 beats with i_full=0 SHALL give o_wr high for 4 cycles starting 1 cycle after the request, a 1-cycle gap, then regrant to 0.
REQ-031 i_req=4'b1111 held continuously SHALL give a grant order of 0,1,2,3,0 with 4 beats each and o_ack one-hot matching o_grant_id.
REQ-032 With owner 2 after 2 beats and i_full=1 for 3 cycles SHALL give o_wr=0 during the stall, grant held, then exactly 2 more beats.
REQ-033 Owner 1 dropping i_req after 1 beat SHALL give GRANT exit on the next edge, r_last=1, and requester 3 (i_req=4'b1010) granted next.
REQ-034 Asserting i_rst_n low mid-burst SHALL give all outputs at reset values asynchronously, and requester 0 SHALL be granted first after release.
REQ-035 With FIFO_ARB_STATS_EN, 70000 single-requester grants SHALL leave o_grant_cnt[0] saturated at 16'hFFFF.
